// File: rtl/stim_channel_sequencer.sv
// Steps through the enabled electrode channels in ascending order, holding each for a
// programmed on-time with an optional idle gap, and drives the channel code to Decoder8.
module stim_channel_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [7:0]       i_ch_mask,
  input  logic [CNT_W-1:0] i_on_cycles,
  input  logic [CNT_W-1:0] i_gap_cycles,
  input  logic             i_continuous,
  output logic [3:0]       o_ch_code,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_mask;
  logic [CNT_W-1:0] r_on, r_gap;
  logic             r_cont;
  logic             w_latch, w_fin;
  logic [3:0]       r_code, w_code_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       w_first, w_above, w_wrap;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] f_find(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  assign w_first = f_find(i_ch_mask, 4'd0);
  assign w_above = f_find(r_mask, {1'b0, r_ptr} + 4'd1);
  assign w_wrap  = f_find(r_mask, 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          w_latch = 1'b1;
          if (i_ch_mask == 8'd0 || i_on_cycles == '0) begin
            w_fin = 1'b1;
          end else begin
            w_state_nxt = S_ON;
            w_ptr_nxt   = w_first[2:0];
            w_cnt_nxt   = i_on_cycles - CNT_W'(1);
          end
        end
      end
      S_ON: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_above[3] || r_cont) begin
          // The pointer advances at expiry; ch_code stays 0 through any gap.
          w_ptr_nxt = w_above[3] ? w_above[2:0] : w_wrap[2:0];
          if (r_gap != '0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = r_gap - CNT_W'(1);
          end else begin
            w_cnt_nxt = r_on - CNT_W'(1);
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_fin       = 1'b1;
        end
      end
      S_GAP: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = r_on - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_code_nxt = (w_state_nxt == S_ON) ? ({1'b0, w_ptr_nxt} + 4'd1) : 4'd0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = w_fin;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
      r_on   <= '0;
      r_gap  <= '0;
      r_cont <= 1'b0;
    end else if (w_latch) begin
      r_mask <= i_ch_mask;
      r_on   <= i_on_cycles;
      r_gap  <= i_gap_cycles;
      r_cont <= i_continuous;
    end
  end

  // Outputs are registered from next-state values so Decoder8 never sees glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_code <= w_code_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign o_ch_code = r_code;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_stim_channel_sequencer.sv
// Scoreboard bench for stim_channel_sequencer: per-cycle expected outputs are queued
// when a sequence is launched and compared one entry per clock.
module tb_stim_channel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] mask = 8'd0;
  logic [7:0] on_c = 8'd0;
  logic [7:0] gap_c = 8'd0;
  logic [3:0] code;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [3:0] code;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  string tname = "reset";

  stim_channel_sequencer #(.CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_ch_mask(mask), .i_on_cycles(on_c), .i_gap_cycles(gap_c),
    .i_continuous(cont), .o_ch_code(code), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input logic [3:0] c, input logic b, input logic d);
    exp_t e;
    e.code = c;
    e.busy = b;
    e.done = d;
    repeat (n) sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      check_eq($sformatf("%s_c%0d_sb_underflow", tname, cyc), sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check_eq($sformatf("%s_c%0d_code", tname, cyc), int'(code), int'(e.code));
      check_eq($sformatf("%s_c%0d_busy", tname, cyc), int'(busy), int'(e.busy));
      check_eq($sformatf("%s_c%0d_done", tname, cyc), int'(done), int'(e.done));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
    end
  endtask

  task automatic kick(input string name, input logic [7:0] m, input logic [7:0] on,
                      input logic [7:0] gap, input logic c);
    tname = name;
    cyc   = 0;
    mask  = m;
    on_c  = on;
    gap_c = gap;
    cont  = c;
    start = 1'b1;
  endtask

  task automatic drain();
    check_eq({tname, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_code", int'(code), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two channels with gap, single pass
    kick("t1", 8'h05, 8'd3, 8'd2, 1'b0);
    push(3, 4'd1, 1'b1, 1'b0); push(2, 4'd0, 1'b1, 1'b0);
    push(3, 4'd3, 1'b1, 1'b0); push(1, 4'd0, 1'b0, 1'b1);
    push(2, 4'd0, 1'b0, 1'b0);
    run(11); drain();

    // All channels back-to-back
    kick("t2", 8'hFF, 8'd1, 8'd0, 1'b0);
    for (int c = 1; c <= 8; c++) push(1, 4'(c), 1'b1, 1'b0);
    push(1, 4'd0, 1'b0, 1'b1); push(1, 4'd0, 1'b0, 1'b0);
    run(10); drain();

    // Single channel continuous, stopped in cycle 12
    kick("t3", 8'h80, 8'd2, 8'd0, 1'b1);
    push(12, 4'd8, 1'b1, 1'b0); push(8, 4'd0, 1'b0, 1'b0);
    run(12); stop = 1'b1; run(1); stop = 1'b0; run(7); drain();

    // Empty mask and zero on-time both complete immediately
    kick("t4a", 8'h00, 8'd5, 8'd1, 1'b0);
    push(1, 4'd0, 1'b0, 1'b1); push(3, 4'd0, 1'b0, 1'b0);
    run(4); drain();
    kick("t4b", 8'h0F, 8'd0, 8'd1, 1'b0);
    push(1, 4'd0, 1'b0, 1'b1); push(3, 4'd0, 1'b0, 1'b0);
    run(4); drain();

    // Mid-sequence config change and restart are ignored
    kick("t5", 8'h12, 8'd4, 8'd1, 1'b0);
    push(4, 4'd2, 1'b1, 1'b0); push(1, 4'd0, 1'b1, 1'b0);
    push(4, 4'd5, 1'b1, 1'b0); push(1, 4'd0, 1'b0, 1'b1);
    push(1, 4'd0, 1'b0, 1'b0);
    run(1); mask = 8'hFF; on_c = 8'd1;
    run(1); start = 1'b1;
    run(9); drain();

    // start and stop together in IDLE
    kick("t7", 8'h01, 8'd2, 8'd0, 1'b0);
    stop = 1'b1;
    push(3, 4'd0, 1'b0, 1'b0);
    run(1); stop = 1'b0; run(2); drain();

    // Continuous wrap through gaps, stopped during ON
    kick("t8", 8'h81, 8'd1, 8'd1, 1'b1);
    push(1, 4'd1, 1'b1, 1'b0); push(1, 4'd0, 1'b1, 1'b0);
    push(1, 4'd8, 1'b1, 1'b0); push(1, 4'd0, 1'b1, 1'b0);
    push(1, 4'd1, 1'b1, 1'b0); push(2, 4'd0, 1'b0, 1'b0);
    run(5); stop = 1'b1; run(1); stop = 1'b0; run(1); drain();

    // Stop during GAP
    kick("t9", 8'h03, 8'd2, 8'd3, 1'b0);
    push(2, 4'd1, 1'b1, 1'b0); push(1, 4'd0, 1'b1, 1'b0);
    push(3, 4'd0, 1'b0, 1'b0);
    run(3); stop = 1'b1; run(1); stop = 1'b0; run(2); drain();

    // Maximum on-time and gap-time
    kick("t10", 8'h01, 8'd255, 8'd0, 1'b0);
    push(255, 4'd1, 1'b1, 1'b0); push(1, 4'd0, 1'b0, 1'b1);
    run(256); drain();
    kick("t11", 8'h03, 8'd1, 8'd255, 1'b0);
    push(1, 4'd1, 1'b1, 1'b0); push(255, 4'd0, 1'b1, 1'b0);
    push(1, 4'd2, 1'b1, 1'b0); push(1, 4'd0, 1'b0, 1'b1);
    run(258); drain();

    // Asynchronous reset mid-ON
    kick("t6", 8'h10, 8'd4, 8'd0, 1'b0);
    push(2, 4'd5, 1'b1, 1'b0);
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_code", int'(code), 0);
    check_eq("t6_async_busy", int'(busy), 0);
    check_eq("t6_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tname = "t6_post";
    cyc = 0;
    push(4, 4'd0, 1'b0, 1'b0);
    run(4); drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
